// File: rtl/slot_scheduler.sv
// Four-way time-slot arbiter with a rotating one-hot slot pointer and registered grants.
// Define SLOT_SKIP_EN for work-conserving mode; leave it undefined for strict TDM rotation.
module slot_scheduler #(
  parameter int SLOT_LEN = 20,
  parameter int CW       = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    req,
  input  logic [3:0]    done,
  output logic [3:0]    grant,
  output logic [3:0]    slot_ptr,
  output logic [CW-1:0] slot_cnt,
  output logic          busy
);

  localparam logic [CW-1:0] LAST_CNT = CW'(SLOT_LEN - 1);

  logic [3:0]    r_grant;
  logic [3:0]    r_ptr;
  logic [CW-1:0] r_cnt;
  logic          r_busy;

  logic          w_last;
  logic          w_release;

  assign w_last = (r_cnt == LAST_CNT);
  // The current owner gives up its slot through done or by dropping req.
  assign w_release = (|r_grant) && ((|(done & r_grant)) || !(|(req & r_grant)));

`ifndef SLOT_SKIP_EN

  logic          r_started;
  logic          r_released;
  logic          w_boundary;
  logic [3:0]    w_rotl;
  logic [3:0]    w_ptr_next;
  logic          w_released_next;
  logic [3:0]    w_grant_next;

  // The first cycle after reset opens slot 1000 without counting it as a slot cycle.
  assign w_boundary      = r_started && w_last;
  assign w_rotl          = {r_ptr[2:0], r_ptr[3]};
  assign w_ptr_next      = w_boundary ? w_rotl : r_ptr;
  assign w_released_next = w_boundary ? 1'b0 : (r_released | w_release);
  assign w_grant_next    = w_ptr_next & req & {4{~w_released_next}};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_started  <= 1'b0;
      r_released <= 1'b0;
      r_ptr      <= 4'b1000;
      r_cnt      <= '0;
      r_grant    <= 4'b0000;
      r_busy     <= 1'b0;
    end else begin
      r_started  <= 1'b1;
      r_released <= w_released_next;
      r_ptr      <= w_ptr_next;
      r_grant    <= w_grant_next;
      r_busy     <= |w_grant_next;
      if (w_boundary) begin
        r_cnt <= '0;
      end else if (r_started) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

`else

  typedef enum logic {ST_IDLE, ST_OWN} state_t;

  state_t     r_state;
  logic [7:0] w_dbl;
  logic [3:0] w_cand [4];
  logic [3:0] w_winner;
  logic       w_found;

  assign w_dbl = {r_ptr, r_ptr};

  // w_cand[k] is the pointer rotated left k+1 times; the last entry is the pointer itself.
  for (genvar gi = 0; gi < 4; gi++) begin : g_cand
    assign w_cand[gi] = w_dbl[6-gi -: 4];
  end

  always_comb begin
    w_winner = 4'b0000;
    w_found  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!w_found && (|(w_cand[k] & req))) begin
        w_winner = w_cand[k];
        w_found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ptr   <= 4'b1000;
      r_cnt   <= '0;
      r_grant <= 4'b0000;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_found) begin
            r_grant <= w_winner;
            r_ptr   <= w_winner;
            r_busy  <= 1'b1;
            r_state <= ST_OWN;
          end else begin
            r_grant <= 4'b0000;
            r_busy  <= 1'b0;
          end
        end
        ST_OWN: begin
          // Every slot end passes through IDLE, giving the mandatory dead cycle.
          if (w_release || w_last) begin
            r_grant <= 4'b0000;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_grant <= 4'b0000;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`endif

  assign grant    = r_grant;
  assign slot_ptr = r_ptr;
  assign slot_cnt = r_cnt;
  assign busy     = r_busy;

endmodule

// File: tb/tb_slot_scheduler.sv
// Randomized self-checking bench for slot_scheduler against a slot-level reference model.
// Follows SLOT_SKIP_EN the same way the design does.
module tb_slot_scheduler;
  localparam int LEN = 20;
  localparam int CW  = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    req = 4'b0000;
  logic [3:0]    done = 4'b0000;
  logic [3:0]    grant;
  logic [3:0]    slot_ptr;
  logic [CW-1:0] slot_cnt;
  logic          busy;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         m_t = 0;
  bit         m_rel = 1'b0;
  int         m_own = -1;
  int         m_p = 3;
  int         m_cnt = 0;
  logic [3:0] exp_grant = 4'b0000;
  logic [3:0] exp_ptr = 4'b1000;
  int         exp_cnt = 0;
  logic       exp_busy = 1'b0;

  slot_scheduler #(.SLOT_LEN(LEN), .CW(CW)) dut (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .grant(grant), .slot_ptr(slot_ptr), .slot_cnt(slot_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Advance the model by one clock edge using the inputs held across that edge.
  task automatic model_step();
`ifndef SLOT_SKIP_EN
    logic [3:0] prev_g;
    int         prev_slot;
    int         slot;
    bit         rel_evt;
    prev_g = exp_grant;
    if (reset) begin
      m_t = 0; m_rel = 1'b0;
      exp_grant = 4'b0000; exp_ptr = 4'b1000; exp_cnt = 0; exp_busy = 1'b0;
      return;
    end
    prev_slot = (m_t == 0) ? -1 : (m_t - 1) / LEN;
    rel_evt = (prev_g != 4'b0000) && (((done & prev_g) != 4'b0000) || ((req & prev_g) == 4'b0000));
    m_t++;
    slot = (m_t - 1) / LEN;
    if (slot != prev_slot) m_rel = 1'b0;
    else if (rel_evt) m_rel = 1'b1;
    exp_ptr   = 4'b0001 << ((slot + 3) % 4);
    exp_cnt   = (m_t - 1) % LEN;
    exp_grant = m_rel ? 4'b0000 : (exp_ptr & req);
`else
    if (reset) begin
      m_own = -1; m_p = 3; m_cnt = 0;
    end else if (m_own >= 0) begin
      if (done[m_own] || !req[m_own] || m_cnt == LEN - 1) begin
        m_own = -1; m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end else if (req != 4'b0000) begin
      for (int k = 1; k <= 4; k++)
        if (m_own < 0 && req[(m_p + k) % 4]) m_own = (m_p + k) % 4;
      m_p = m_own;
      m_cnt = 0;
    end
    exp_grant = (m_own >= 0) ? (4'b0001 << m_own) : 4'b0000;
    exp_ptr   = 4'b0001 << m_p;
    exp_cnt   = m_cnt;
`endif
    exp_busy = |exp_grant;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = 4'b0000; done = 4'b0000;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 4'($urandom); done = 4'($urandom);
    tick();
    tick();
    checks++;
    if ({grant, slot_ptr, slot_cnt, busy} !== {4'b0000, 4'b1000, CW'(0), 1'b0}) begin
      errors++;
      $display("FAIL reset_state got g=%b p=%b c=%0d b=%b want g=0000 p=1000 c=0 b=0",
               grant, slot_ptr, slot_cnt, busy);
    end
    reset = 1'b0; req = 4'b0000; done = 4'b0000;
  endtask

  task automatic test_reset_mid_slot();
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if ({grant, slot_ptr, slot_cnt, busy} !== {exp_grant, exp_ptr, CW'(exp_cnt), exp_busy}) begin
        errors++;
        $display("FAIL mid_slot_run got g=%b p=%b c=%0d b=%b want g=%b p=%b c=%0d b=%b",
                 grant, slot_ptr, slot_cnt, busy, exp_grant, exp_ptr, exp_cnt, exp_busy);
      end
    end
    checks++;
    if (slot_cnt !== CW'(7)) begin
      errors++;
      $display("FAIL mid_slot_cnt got c=%0d want c=7", slot_cnt);
    end
    reset = 1'b1; done = 4'b0001;
    tick();
    checks++;
    if ({grant, slot_ptr, slot_cnt, busy} !== {4'b0000, 4'b1000, CW'(0), 1'b0}) begin
      errors++;
      $display("FAIL mid_slot_reset got g=%b p=%b c=%0d b=%b want g=0000 p=1000 c=0 b=0",
               grant, slot_ptr, slot_cnt, busy);
    end
    reset = 1'b0; done = 4'b0000; req = 4'b0000;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 11) == 0) req = 4'($urandom);
      done  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      reset = ($urandom_range(0, 199) == 0);
      tick();
      checks++;
      if ({grant, slot_ptr, slot_cnt, busy} !== {exp_grant, exp_ptr, CW'(exp_cnt), exp_busy}) begin
        errors++;
        $display("FAIL random cyc=%0d req=%b done=%b got g=%b p=%b c=%0d b=%b want g=%b p=%b c=%0d b=%b",
                 i, req, done, grant, slot_ptr, slot_cnt, busy, exp_grant, exp_ptr, exp_cnt, exp_busy);
      end
    end
    reset = 1'b0; done = 4'b0000; req = 4'b0000;
  endtask

`ifndef SLOT_SKIP_EN
  task automatic test_full_rotation();
    logic [3:0] want;
    do_reset();
    req = 4'b1111;
    for (int cyc = 1; cyc <= 85; cyc++) begin
      tick();
      case (((cyc - 1) / LEN) % 4)
        0:       want = 4'b1000;
        1:       want = 4'b0001;
        2:       want = 4'b0010;
        default: want = 4'b0100;
      endcase
      checks++;
      if (grant !== want || slot_ptr !== want || slot_cnt !== CW'((cyc - 1) % LEN) || busy !== 1'b1) begin
        errors++;
        $display("FAIL rotation cyc=%0d got g=%b p=%b c=%0d b=%b want g=%b p=%b c=%0d b=1",
                 cyc, grant, slot_ptr, slot_cnt, busy, want, want, (cyc - 1) % LEN);
      end
    end
  endtask

  task automatic test_early_done();
    logic [3:0] want_g;
    logic [3:0] want_p;
    do_reset();
    req = 4'b0001;
    for (int cyc = 1; cyc <= 105; cyc++) begin
      done = (exp_ptr == 4'b0001 && exp_cnt == 5) ? 4'b0001 : 4'b0000;
      tick();
      checks++;
      if ({grant, slot_ptr, slot_cnt, busy} !== {exp_grant, exp_ptr, CW'(exp_cnt), exp_busy}) begin
        errors++;
        $display("FAIL early_done cyc=%0d got g=%b p=%b c=%0d b=%b want g=%b p=%b c=%0d b=%b",
                 cyc, grant, slot_ptr, slot_cnt, busy, exp_grant, exp_ptr, exp_cnt, exp_busy);
      end
      if (cyc == 26 || cyc == 27 || cyc == 40 || cyc == 41 || cyc == 101) begin
        case (cyc)
          26:      begin want_g = 4'b0001; want_p = 4'b0001; end
          27:      begin want_g = 4'b0000; want_p = 4'b0001; end
          40:      begin want_g = 4'b0000; want_p = 4'b0001; end
          41:      begin want_g = 4'b0000; want_p = 4'b0010; end
          default: begin want_g = 4'b0001; want_p = 4'b0001; end
        endcase
        checks++;
        if (grant !== want_g || slot_ptr !== want_p) begin
          errors++;
          $display("FAIL early_done_point cyc=%0d got g=%b p=%b want g=%b p=%b",
                   cyc, grant, slot_ptr, want_g, want_p);
        end
      end
    end
    done = 4'b0000;
  endtask
`else
  task automatic test_lone_requester();
    logic [3:0] want;
    do_reset();
    req = 4'b0100;
    for (int cyc = 1; cyc <= 45; cyc++) begin
      tick();
      want = (((cyc - 1) % (LEN + 1)) == LEN) ? 4'b0000 : 4'b0100;
      checks++;
      if (grant !== want || slot_ptr !== 4'b0100 || busy !== (want != 4'b0000)) begin
        errors++;
        $display("FAIL lone_requester cyc=%0d got g=%b p=%b b=%b want g=%b p=0100",
                 cyc, grant, slot_ptr, busy, want);
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_scan_order();
    do_reset();
    req = 4'b0001;
    tick();
    req = 4'b0000;
    tick();
    req = 4'b1001;
    tick();
    checks++;
    if (grant !== 4'b1000 || slot_ptr !== 4'b1000 || slot_cnt !== CW'(0)) begin
      errors++;
      $display("FAIL scan_order got g=%b p=%b c=%0d want g=1000 p=1000 c=0", grant, slot_ptr, slot_cnt);
    end
    for (int i = 1; i < LEN; i++) begin
      tick();
      checks++;
      if ({grant, slot_ptr, slot_cnt, busy} !== {exp_grant, exp_ptr, CW'(exp_cnt), exp_busy}) begin
        errors++;
        $display("FAIL scan_hold i=%0d got g=%b p=%b c=%0d b=%b want g=%b p=%b c=%0d b=%b",
                 i, grant, slot_ptr, slot_cnt, busy, exp_grant, exp_ptr, exp_cnt, exp_busy);
      end
    end
    done = 4'b1000;
    tick();
    done = 4'b0000;
    checks++;
    if (grant !== 4'b0000 || slot_cnt !== CW'(0) || busy !== 1'b0) begin
      errors++;
      $display("FAIL double_end_dead got g=%b c=%0d b=%b want g=0000 c=0 b=0", grant, slot_cnt, busy);
    end
    tick();
    checks++;
    if (grant !== 4'b0001 || slot_ptr !== 4'b0001) begin
      errors++;
      $display("FAIL double_end_next got g=%b p=%b want g=0001 p=0001", grant, slot_ptr);
    end
    req = 4'b0000;
  endtask

  task automatic test_req_drop();
    do_reset();
    req = 4'b0010;
    tick();
    done = 4'b0100;
    tick();
    done = 4'b0000;
    checks++;
    if (grant !== 4'b0010 || slot_cnt !== CW'(1)) begin
      errors++;
      $display("FAIL nonowner_done got g=%b c=%0d want g=0010 c=1", grant, slot_cnt);
    end
    tick();
    tick();
    checks++;
    if (slot_cnt !== CW'(3)) begin
      errors++;
      $display("FAIL req_drop_cnt got c=%0d want c=3", slot_cnt);
    end
    req = 4'b0000;
    tick();
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0 || slot_ptr !== 4'b0010) begin
      errors++;
      $display("FAIL req_drop got g=%b b=%b p=%b want g=0000 b=0 p=0010", grant, busy, slot_ptr);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifndef SLOT_SKIP_EN
    test_full_rotation();
    test_early_done();
`else
    test_lone_requester();
    test_scan_order();
    test_req_drop();
`endif
    test_reset_mid_slot();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
